// File: rtl/usbdev_pkg.sv
// Shared USB device types and constants for the wake transmitter and its neighbours.
package usbdev_pkg;

  // Remote-wakeup transmitter states; encodings are fixed so the debug
  // state output reads the same in every build.
  typedef enum logic [2:0] {
    WAKE_IDLE      = 3'd0,
    WAKE_WAIT_IDLE = 3'd1,
    WAKE_DRIVE     = 3'd2,
    WAKE_RELEASE   = 3'd3,
    WAKE_WAIT_HOST = 3'd4
  } wake_state_e;

  // Extra bus idle required after suspend entry before remote wakeup may
  // start (detector's 3 ms timeout plus this gives the 5 ms minimum).
  localparam int unsigned USB_WAKE_MIN_IDLE_US  = 2000;

  // Legal window for the resume K drive.
  localparam int unsigned USB_WAKE_MIN_DRIVE_US = 1000;
  localparam int unsigned USB_WAKE_MAX_DRIVE_US = 15000;

  // {dp, dn} for a K state, honouring a swapped D+/D- pair.
  function automatic logic [1:0] usb_k_pair(input logic pinflip);
    return pinflip ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/usbdev_us_timer.sv
// Microsecond phase timer: saturating counter with clear, tick enable and
// terminal-count compare. hit_o fires on the tick that makes cnt == limit,
// so a phase of length N lasts exactly N ticks after the last clear.
module usbdev_us_timer #(
  parameter int TimerW = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              tick_i,
  input  logic [TimerW-1:0] limit_i,
  output logic [TimerW-1:0] cnt_o,
  output logic              hit_o
);

  localparam logic [TimerW-1:0] One = TimerW'(1);

  logic [TimerW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count ticks and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + One;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count is independent of clr_i so the owner can derive its
  // clear from the next state without a combinational loop.
  assign hit_o = tick_i && (cnt_q == (limit_i - One));
  assign cnt_o = cnt_q;

endmodule

// File: rtl/usbdev_wake_tx.sv
// Device-side USB remote-wakeup transmitter. From suspend, on request, waits
// for sustained bus idle, drives K for a fixed time, releases the bus and
// waits for the host to continue resume signalling.
// Pulse outputs (wake_done_o / wake_abort_o) are single-cycle and never
// asserted together; wake_req_i / wake_cancel_i are single-cycle requests.
module usbdev_wake_tx
  import usbdev_pkg::*;
#(
  parameter int unsigned IdleMinUs  = USB_WAKE_MIN_IDLE_US,
  parameter int unsigned DriveUs    = 2000,
  parameter int unsigned HostWaitUs = 25000,
  parameter int          TimerW     = 15
) (
  input  logic       clk_48mhz_i,
  input  logic       rst_ni,
  input  logic       us_tick_i,
  input  logic       wake_req_i,
  input  logic       wake_cancel_i,
  input  logic       link_suspend_i,
  input  logic       link_reset_i,
  input  logic       link_disconnect_i,
  input  logic       rx_idle_det_i,
  input  logic       pinflip_i,
  output logic       wake_oe_o,
  output logic       wake_dp_o,
  output logic       wake_dn_o,
  output logic       wake_busy_o,
  output logic       wake_done_o,
  output logic       wake_abort_o,
  output logic [2:0] wake_state_o
);

  wake_state_e       state_q, state_d;
  logic              abort_ev, done_ev, idle_restart;
  logic              tmr_clr, tmr_hit;
  logic [TimerW-1:0] tmr_limit, tmr_cnt;

  logic oe_q, oe_d, dp_q, dp_d, dn_q, dn_d;
  logic busy_q, busy_d, done_q, done_d, abort_q, abort_d;

  // Phase timer; restarted on every state change and on loss of bus idle.
  usbdev_us_timer #(.TimerW(TimerW)) u_timer (
    .clk_i   (clk_48mhz_i),
    .rst_ni  (rst_ni),
    .clr_i   (tmr_clr),
    .tick_i  (us_tick_i),
    .limit_i (tmr_limit),
    .cnt_o   (tmr_cnt),
    .hit_o   (tmr_hit)
  );

  // Phase length for the current state.
  always_comb begin
    tmr_limit = '1;
    unique case (state_q)
      WAKE_WAIT_IDLE: tmr_limit = TimerW'(IdleMinUs);
      WAKE_DRIVE:     tmr_limit = TimerW'(DriveUs);
      WAKE_WAIT_HOST: tmr_limit = TimerW'(HostWaitUs);
      default:        tmr_limit = '1;
    endcase
  end

  // State register.
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WAKE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and done/abort events. Link loss, bus reset and cancel
  // override any normal transition; all three end in Idle with abort.
  always_comb begin
    state_d      = state_q;
    abort_ev     = 1'b0;
    done_ev      = 1'b0;
    idle_restart = 1'b0;
    if (state_q != WAKE_IDLE &&
        (link_disconnect_i || link_reset_i || wake_cancel_i)) begin
      state_d  = WAKE_IDLE;
      abort_ev = 1'b1;
    end else begin
      unique case (state_q)
        WAKE_IDLE: begin
          if (wake_req_i) begin
            if (link_suspend_i && !link_disconnect_i) state_d  = WAKE_WAIT_IDLE;
            else                                      abort_ev = 1'b1;
          end
        end
        WAKE_WAIT_IDLE: begin
          if (!link_suspend_i) begin
            // Host resumed before we could.
            state_d  = WAKE_IDLE;
            abort_ev = 1'b1;
          end else if (!rx_idle_det_i) begin
            idle_restart = 1'b1;
          end else if (tmr_hit) begin
            state_d = WAKE_DRIVE;
          end
        end
        // Our own K clears suspend/idle detection, so only the timer counts.
        WAKE_DRIVE: if (tmr_hit) state_d = WAKE_RELEASE;
        WAKE_RELEASE: state_d = WAKE_WAIT_HOST;
        WAKE_WAIT_HOST: begin
          if (!link_suspend_i) begin
            state_d = WAKE_IDLE;
            done_ev = 1'b1;
          end else if (tmr_hit) begin
            state_d  = WAKE_IDLE;
            abort_ev = 1'b1;
          end
        end
        default: state_d = WAKE_IDLE;
      endcase
    end
  end

  assign tmr_clr = (state_d != state_q) || idle_restart || (state_q == WAKE_IDLE);

  // Output values for the next cycle, taken from the next state so the
  // registered drive enable tracks the state register exactly.
  always_comb begin
    oe_d    = (state_d == WAKE_DRIVE);
    dp_d    = 1'b0;
    dn_d    = 1'b0;
    if (oe_d) {dp_d, dn_d} = usb_k_pair(pinflip_i);
    busy_d  = (state_d != WAKE_IDLE);
    done_d  = done_ev;
    abort_d = abort_ev;
  end

  // Output registers.
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oe_q    <= 1'b0;
      dp_q    <= 1'b0;
      dn_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      oe_q    <= oe_d;
      dp_q    <= dp_d;
      dn_q    <= dn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign wake_oe_o    = oe_q;
  assign wake_dp_o    = dp_q;
  assign wake_dn_o    = dn_q;
  assign wake_busy_o  = busy_q;
  assign wake_done_o  = done_q;
  assign wake_abort_o = abort_q;
  assign wake_state_o = state_q;

  // K drive duration must stay inside the legal resume window.
  drive_range_a: assert property (@(posedge clk_48mhz_i)
    (DriveUs >= USB_WAKE_MIN_DRIVE_US) && (DriveUs <= USB_WAKE_MAX_DRIVE_US));

  // Every phase length must fit in the timer.
  timer_width_a: assert property (@(posedge clk_48mhz_i)
    (IdleMinUs < (1 << TimerW)) && (DriveUs < (1 << TimerW)) &&
    (HostWaitUs < (1 << TimerW)));

endmodule

// File: tb/tb_usbdev_wake_tx.sv
// Directed bench for usbdev_wake_tx. us_tick_i is held high (one tick per
// clock) except where a tick gap is exercised on purpose.
module tb_usbdev_wake_tx;
  import usbdev_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n;
  logic       us_tick, wake_req, wake_cancel;
  logic       link_suspend, link_reset, link_disconnect, rx_idle_det, pinflip;
  logic       wake_oe, wake_dp, wake_dn, wake_busy, wake_done, wake_abort;
  logic [2:0] wake_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int n;

  usbdev_wake_tx dut (
    .clk_48mhz_i       (clk),
    .rst_ni            (rst_n),
    .us_tick_i         (us_tick),
    .wake_req_i        (wake_req),
    .wake_cancel_i     (wake_cancel),
    .link_suspend_i    (link_suspend),
    .link_reset_i      (link_reset),
    .link_disconnect_i (link_disconnect),
    .rx_idle_det_i     (rx_idle_det),
    .pinflip_i         (pinflip),
    .wake_oe_o         (wake_oe),
    .wake_dp_o         (wake_dp),
    .wake_dn_o         (wake_dn),
    .wake_busy_o       (wake_busy),
    .wake_done_o       (wake_done),
    .wake_abort_o      (wake_abort),
    .wake_state_o      (wake_state)
  );

  // Driver tasks: advance one edge and settle, inputs change after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  task automatic pulse_req();
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
  endtask

  // Bounded waits; a blown bound shows up as a wrong count.
  task automatic count_until_oe(input logic level, output int cnt);
    cnt = 0;
    while (wake_oe !== level && cnt < 30000) begin
      step();
      cnt++;
    end
  endtask

  task automatic count_until_abort(output int cnt);
    cnt = 0;
    while (wake_abort !== 1'b1 && cnt < 30000) begin
      step();
      cnt++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; us_tick = 1'b1; wake_req = 1'b0; wake_cancel = 1'b0;
    link_suspend = 1'b1; link_reset = 1'b0; link_disconnect = 1'b0;
    rx_idle_det = 1'b1; pinflip = 1'b0;

    // Reset state
    steps(3);
    check("rst_oe",    wake_oe,    0);
    check("rst_dpdn",  {wake_dp, wake_dn}, 0);
    check("rst_busy",  wake_busy,  0);
    check("rst_done",  wake_done,  0);
    check("rst_abort", wake_abort, 0);
    check("rst_state", wake_state, WAKE_IDLE);
    rst_n = 1'b1;
    step();

    // 1: full wake, done 100 ticks after release
    pulse_req();
    check("t1_busy",  wake_busy, 1);
    check("t1_state", wake_state, WAKE_WAIT_IDLE);
    count_until_oe(1'b1, n);
    check("t1_idle_len", n, 2000);
    check("t1_k", {wake_dp, wake_dn}, 2'b01);
    check("t1_state_drive", wake_state, WAKE_DRIVE);
    count_until_oe(1'b0, n);
    check("t1_drive_len", n, 2000);
    check("t1_state_rel", wake_state, WAKE_RELEASE);
    check("t1_dpdn_off", {wake_dp, wake_dn}, 0);
    step();
    check("t1_state_wh", wake_state, WAKE_WAIT_HOST);
    steps(100);
    check("t1_done_early", wake_done, 0);
    link_suspend = 1'b0;
    step();
    check("t1_done",  wake_done,  1);
    check("t1_abort", wake_abort, 0);
    check("t1_busy0", wake_busy,  0);
    step();
    check("t1_done_pulse", wake_done, 0);
    link_suspend = 1'b1;

    // 2: pinflip, plus a tick gap that must not count
    pinflip = 1'b1;
    pulse_req();
    us_tick = 1'b0;
    steps(37);
    check("t2_no_oe_gap", wake_oe, 0);
    us_tick = 1'b1;
    count_until_oe(1'b1, n);
    check("t2_idle_len", n, 2000);
    check("t2_k_flip", {wake_dp, wake_dn}, 2'b10);
    count_until_oe(1'b0, n);
    check("t2_drive_len", n, 2000);
    step();
    link_suspend = 1'b0;
    step();
    check("t2_done", wake_done, 1);
    link_suspend = 1'b1;
    pinflip = 1'b0;
    step();

    // 3: idle glitch at tick 1500 restarts the idle wait
    pulse_req();
    steps(1500);
    rx_idle_det = 1'b0;
    step();
    rx_idle_det = 1'b1;
    count_until_oe(1'b1, n);
    check("t3_restart_len", n, 2000);
    wake_cancel = 1'b1;
    step();
    wake_cancel = 1'b0;
    check("t3_cancel_oe",    wake_oe,    0);
    check("t3_cancel_abort", wake_abort, 1);
    check("t3_cancel_state", wake_state, WAKE_IDLE);
    step();
    check("t3_abort_pulse", wake_abort, 0);

    // 4: bus reset 500 ticks into Drive
    pulse_req();
    count_until_oe(1'b1, n);
    check("t4_idle_len", n, 2000);
    steps(500);
    check("t4_still_oe", wake_oe, 1);
    link_reset = 1'b1;
    step();
    check("t4_oe",    wake_oe,    0);
    check("t4_dpdn",  {wake_dp, wake_dn}, 0);
    check("t4_abort", wake_abort, 1);
    check("t4_done",  wake_done,  0);
    check("t4_state", wake_state, WAKE_IDLE);
    link_reset = 1'b0;
    step();
    check("t4_abort_pulse", wake_abort, 0);

    // 5: rejected request, ignored request in Drive, disconnect
    link_suspend = 1'b0;
    pulse_req();
    check("t5_rej_abort", wake_abort, 1);
    check("t5_rej_oe",    wake_oe,    0);
    check("t5_rej_busy",  wake_busy,  0);
    step();
    check("t5_rej_pulse", wake_abort, 0);
    link_suspend = 1'b1;
    wake_cancel = 1'b1;
    step();
    wake_cancel = 1'b0;
    check("t5_cancel_idle", wake_abort, 0);
    pulse_req();
    count_until_oe(1'b1, n);
    check("t5_idle_len", n, 2000);
    pulse_req();
    check("t5_req_ign_abort", wake_abort, 0);
    check("t5_req_ign_state", wake_state, WAKE_DRIVE);
    check("t5_req_ign_oe",    wake_oe,    1);
    link_disconnect = 1'b1;
    step();
    check("t5_disc_oe",    wake_oe,    0);
    check("t5_disc_abort", wake_abort, 1);
    step();
    check("t5_disc_pulse", wake_abort, 0);
    pulse_req();
    check("t5_disc_rej", wake_abort, 1);
    check("t5_disc_rej_busy", wake_busy, 0);
    link_disconnect = 1'b0;
    step();

    // Async reset mid-Drive
    pulse_req();
    count_until_oe(1'b1, n);
    check("ar_idle_len", n, 2000);
    steps(10);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_oe",    wake_oe,    0);
    check("ar_abort", wake_abort, 0);
    check("ar_done",  wake_done,  0);
    check("ar_state", wake_state, WAKE_IDLE);
    steps(3);
    check("ar_abort_hold", wake_abort, 0);
    rst_n = 1'b1;
    step();

    // 6: no host takeover, abort after exactly 25000 ticks
    pulse_req();
    count_until_oe(1'b1, n);
    check("t6_idle_len", n, 2000);
    count_until_oe(1'b0, n);
    check("t6_drive_len", n, 2000);
    step();
    check("t6_state_wh", wake_state, WAKE_WAIT_HOST);
    count_until_abort(n);
    check("t6_host_wait", n, 25000);
    check("t6_done",  wake_done,  0);
    check("t6_state", wake_state, WAKE_IDLE);
    check("t6_busy",  wake_busy,  0);
    step();
    check("t6_abort_pulse", wake_abort, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
